data_mem_responder: RTL and testbench

- Responder side of the RISCV core's data-memory interface. The core drives address (alu_result), write data, write strobe and load/store funct3; this block returns read_data in the same cycle.
- Contains word-addressed data RAM plus an MMIO register window used by the Game-of-Life program:
  - free-running cycle counter
  - LED register
  - frame-handshake registers toward the display logic.

---
 rtl/riscv_mem_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 94 +++++++++
 rtl/data_mem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared constants for the data-memory responder:
//   - load/store funct3 encodings
//   - MMIO register word offsets relative to the MMIO base address
//   - address region classification used by the decoder
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

  // Load/store size and sign encodings (RV32I funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // MMIO register byte offsets inside the window
  localparam logic [4:0] OFF_CYCLE_LO = 5'h00;
  localparam logic [4:0] OFF_CYCLE_HI = 5'h04;
  localparam logic [4:0] OFF_LED      = 5'h08;
  localparam logic [4:0] OFF_FRAME    = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // Size of the MMIO window in bytes (five 32-bit registers)
  localparam logic [31:0] MMIO_WINDOW_BYTES = 32'd20;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } addr_region_t;

  // True when funct3 names one of the five RV32I load flavours
  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // True when funct3 names one of the three RV32I store sizes
  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the data-memory interface.
// Ports:
//   funct3      in   load/store size and sign selector
//   addr_lo     in   byte offset within the 32-bit word (addr[1:0])
//   store_data  in   LSB-justified store data from the core
//   raw_word    in   full 32-bit word read from RAM or MMIO
//   byte_en     out  per-lane write enables (lane 0 = bits [7:0])
//   store_word  out  store data replicated into every lane it may land in
//   load_data   out  extracted and sign/zero-extended load result
//   misaligned  out  half access on odd address or word access not on 4B
//   load_f3_ok  out  funct3 is a defined load encoding
//   store_f3_ok out  funct3 is a defined store encoding
// -----------------------------------------------------------------------------
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        load_f3_ok,
  output logic        store_f3_ok
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  assign load_f3_ok  = is_load_f3(funct3);
  assign store_f3_ok = is_store_f3(funct3);

  // Store side: lane enables plus replicated data so any enabled lane sees its byte
  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0000_0000;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
      end
      F3_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        store_word = store_data;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed byte/half (little-endian) and extend it
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel_s = raw_word[7:0];
      2'd1:    byte_sel_s = raw_word[15:8];
      2'd2:    byte_sel_s = raw_word[23:16];
      2'd3:    byte_sel_s = raw_word[31:24];
      default: byte_sel_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_sel_s = raw_word[31:16];
    end else begin
      half_sel_s = raw_word[15:0];
    end
    case (funct3)
      F3_B:    load_data = {{24{byte_sel_s[7]}}, byte_sel_s};
      F3_BU:   load_data = {24'h00_0000, byte_sel_s};
      F3_H:    load_data = {{16{half_sel_s[15]}}, half_sel_s};
      F3_HU:   load_data = {16'h0000, half_sel_s};
      F3_W:    load_data = raw_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Alignment check; byte accesses can never be misaligned
  always_comb begin
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder for the single-cycle core's data-memory port: word-addressed RAM
// plus a five-register MMIO window (cycle counter, LEDs, frame handshake,
// status). Loads are combinational; stores and register updates at posedge.
// Ports:
//   clk           in   core clock
//   reset         in   asynchronous active-low reset (RAM is not cleared)
//   mem_addr      in   byte address from the core
//   mem_write     in   store strobe
//   mem_read      in   load strobe, qualifies read side effects (HI snapshot)
//   mem_funct3    in   load/store size and sign
//   write_data    in   LSB-justified store data
//   read_data     out  combinational load data (0 on any access error)
//   leds          out  LED register
//   frame_strobe  out  one-cycle pulse following a FRAME write
//   frame_pending out  frame published and not yet acknowledged
//   frame_ack     in   display consumed the frame
// -----------------------------------------------------------------------------
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          LED_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      mem_addr,
  input  logic             mem_write,
  input  logic             mem_read,
  input  logic [2:0]       mem_funct3,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] leds,
  output logic             frame_strobe,
  output logic             frame_pending,
  input  logic             frame_ack
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  // Storage and MMIO state
  logic [31:0]      ram_q [DEPTH_WORDS];
  logic [63:0]      cycle_q,   cycle_d;
  logic [31:0]      cyc_hi_q,  cyc_hi_d;
  logic [LED_W-1:0] leds_q,    leds_d;
  logic [15:0]      gen_q,     gen_d;
  logic             pending_q, pending_d;
  logic             strobe_q,  strobe_d;
  logic             err_q,     err_d;

  // Decode and datapath
  addr_region_t     region_s;
  logic [31:0]      mmio_off_s;
  logic [IDX_W-1:0] ram_idx_s;
  logic [31:0]      mmio_word_s;
  logic [31:0]      raw_word_s;
  logic [31:0]      load_data_s;
  logic [31:0]      store_word_s;
  logic [3:0]       byte_en_s;
  logic             misaligned_s;
  logic             load_f3_ok_s;
  logic             store_f3_ok_s;
  logic             map_ok_s;
  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             new_err_s;
  logic             ram_we_s;
  logic             mmio_we_s;
  logic             led_we_s;
  logic             frame_we_s;
  logic             status_we_s;
  logic             snap_en_s;

  assign mmio_off_s = mem_addr - MMIO_BASE;
  assign ram_idx_s  = mem_addr[IDX_W+1:2];

  // Address region classification
  always_comb begin
    if (mem_addr < RAM_BYTES) begin
      region_s = REG_RAM;
    end else if ((mem_addr >= MMIO_BASE) && (mmio_off_s < MMIO_WINDOW_BYTES)) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_NONE;
    end
  end

  // MMIO read mux; offsets are word aligned whenever the access is legal
  always_comb begin
    case (mmio_off_s[4:0])
      OFF_CYCLE_LO: mmio_word_s = cycle_q[31:0];
      OFF_CYCLE_HI: mmio_word_s = cyc_hi_q;
      OFF_LED:      mmio_word_s = 32'(leds_q);
      OFF_FRAME:    mmio_word_s = {16'h0000, gen_q};
      OFF_STATUS:   mmio_word_s = {30'h0000_0000, err_q, pending_q};
      default:      mmio_word_s = 32'h0000_0000;
    endcase
  end

  // Source word for the load extractor
  always_comb begin
    if (region_s == REG_RAM) begin
      raw_word_s = ram_q[ram_idx_s];
    end else begin
      raw_word_s = mmio_word_s;
    end
  end

  mem_lane_align u_align (
    .funct3      (mem_funct3),
    .addr_lo     (mem_addr[1:0]),
    .store_data  (write_data),
    .raw_word    (raw_word_s),
    .byte_en     (byte_en_s),
    .store_word  (store_word_s),
    .load_data   (load_data_s),
    .misaligned  (misaligned_s),
    .load_f3_ok  (load_f3_ok_s),
    .store_f3_ok (store_f3_ok_s)
  );

  // MMIO only accepts full-word accesses; everything else there is an error
  assign map_ok_s = (region_s == REG_RAM) ||
                    ((region_s == REG_MMIO) && (mem_funct3 == F3_W));
  assign rd_ok_s  = load_f3_ok_s  & ~misaligned_s & map_ok_s;
  assign wr_ok_s  = store_f3_ok_s & ~misaligned_s & map_ok_s;

  assign read_data = rd_ok_s ? load_data_s : 32'h0000_0000;

  assign new_err_s   = (mem_read & ~rd_ok_s) | (mem_write & ~wr_ok_s);
  assign ram_we_s    = mem_write & wr_ok_s & (region_s == REG_RAM);
  assign mmio_we_s   = mem_write & wr_ok_s & (region_s == REG_MMIO);
  assign led_we_s    = mmio_we_s & (mmio_off_s[4:0] == OFF_LED);
  assign frame_we_s  = mmio_we_s & (mmio_off_s[4:0] == OFF_FRAME);
  assign status_we_s = mmio_we_s & (mmio_off_s[4:0] == OFF_STATUS);
  assign snap_en_s   = mem_read & rd_ok_s & (region_s == REG_MMIO) &
                       (mmio_off_s[4:0] == OFF_CYCLE_LO);

  // Next-state logic for the MMIO registers
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (snap_en_s) begin
      cyc_hi_d = cycle_q[63:32];
    end else begin
      cyc_hi_d = cyc_hi_q;
    end
    if (led_we_s) begin
      leds_d = write_data[LED_W-1:0];
    end else begin
      leds_d = leds_q;
    end
    if (frame_we_s) begin
      gen_d = gen_q + 16'd1;
    end else begin
      gen_d = gen_q;
    end
    // A new frame wins over a simultaneous acknowledge
    if (frame_we_s) begin
      pending_d = 1'b1;
    end else if (frame_ack) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    strobe_d = frame_we_s;
    // A new error wins over a simultaneous clear
    if (new_err_s) begin
      err_d = 1'b1;
    end else if (status_we_s && write_data[1]) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // MMIO state registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= 64'd0;
      cyc_hi_q  <= 32'd0;
      leds_q    <= '0;
      gen_q     <= 16'd0;
      pending_q <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      cyc_hi_q  <= cyc_hi_d;
      leds_q    <= leds_d;
      gen_q     <= gen_d;
      pending_q <= pending_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  // RAM byte-lane writes; contents survive reset, a store during reset is dropped
  always_ff @(posedge clk) begin
    if (ram_we_s && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_s[b]) begin
          ram_q[ram_idx_s][8*b +: 8] <= store_word_s[8*b +: 8];
        end
      end
    end
  end

  assign leds          = leds_q;
  assign frame_strobe  = strobe_q;
  assign frame_pending = pending_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed steps followed by randomized loads/stores, each checked against a
// byte-level reference model of the RAM and the MMIO registers.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MB    = 32'h8000_0000;
  localparam logic [2:0]  LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

  logic        clk, reset, mem_write, mem_read, frame_ack;
  logic [31:0] mem_addr, write_data, read_data;
  logic [2:0]  mem_funct3;
  logic [15:0] leds;
  logic        frame_strobe, frame_pending;

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned tb_cyc;
  logic [31:0] last_rd;

  // Reference model state
  logic [7:0]  m_mem [int unsigned];
  logic [15:0] m_leds, m_gen;
  bit          m_pend, m_err, m_strobe;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .LED_W(16)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_read(mem_read), .mem_funct3(mem_funct3), .write_data(write_data),
    .read_data(read_data), .leds(leds), .frame_strobe(frame_strobe),
    .frame_pending(frame_pending), .frame_ack(frame_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int asz(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int region(input logic [31:0] a);
    if (a < 32'(4 * DEPTH)) return 0;
    if (a >= MB && (a - MB) < 32'd20) return 1;
    return 2;
  endfunction

  function automatic bit acc_ok(input bit is_load, input logic [31:0] a, input logic [2:0] f3);
    bit f3ok;
    int sz;
    int r;
    if (is_load) f3ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    else         f3ok = (f3 == LB) || (f3 == LH) || (f3 == LW);
    if (!f3ok) return 0;
    sz = asz(f3);
    if ((a % sz) != 0) return 0;
    r = region(a);
    return (r == 0) || (r == 1 && sz == 4);
  endfunction

  // Expected load value; known=0 when it depends on the live cycle counter or unwritten RAM
  task automatic ref_read(input logic [31:0] a, input logic [2:0] f3,
                          output logic [31:0] v, output bit known);
    longint unsigned acc;
    int sz;
    known = 1;
    v = 32'h0;
    if (!acc_ok(1, a, f3)) return;
    sz = asz(f3);
    if (region(a) == 0) begin
      acc = 0;
      for (int i = sz - 1; i >= 0; i--) begin
        if (!m_mem.exists(a + 32'(i))) known = 0;
        else acc = acc * 256 + 64'(m_mem[a + 32'(i)]);
      end
      if (f3[2] == 1'b0 && sz < 4 && acc >= (64'd1 << (8 * sz - 1)))
        acc = acc - (64'd1 << (8 * sz));
      v = acc[31:0];
    end else begin
      case (a - MB)
        32'd8:   v = 32'(m_leds);
        32'd12:  v = 32'(m_gen);
        32'd16:  v = {30'd0, m_err, m_pend};
        default: known = 0;
      endcase
    end
  endtask

  // Apply the effects of one clocked access to the model
  task automatic ref_commit(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] wd, input bit ack);
    bit bad;
    bit fw;
    logic [31:0] t;
    bad = (rd && !acc_ok(1, a, f3)) || (wr && !acc_ok(0, a, f3));
    fw  = 0;
    if (wr && acc_ok(0, a, f3)) begin
      if (region(a) == 0) begin
        for (int i = 0; i < asz(f3); i++) begin
          t = wd >> (8 * i);
          m_mem[a + 32'(i)] = t[7:0];
        end
      end else begin
        case (a - MB)
          32'd8:   m_leds = wd[15:0];
          32'd12:  begin m_gen = m_gen + 16'd1; fw = 1; end
          32'd16:  if (wd[1]) m_err = 0;
          default: ;
        endcase
      end
    end
    if (fw) m_pend = 1;
    else if (ack) m_pend = 0;
    m_strobe = fw;
    if (bad) m_err = 1;
  endtask

  // One bus cycle: drive at negedge, check load data, clock, check registered outputs
  task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] wd, input bit ack, input string tag);
    logic [31:0] ev;
    bit known;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_funct3 = f3;
    write_data = wd; frame_ack = ack;
    #1;
    last_rd = read_data;
    ref_read(a, f3, ev, known);
    if (rd && known) chk({tag, "_rd"}, 64'(last_rd), 64'(ev));
    @(posedge clk);
    ref_commit(rd, wr, a, f3, wd, ack);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; frame_ack = 1'b0;
    chk({tag, "_strobe"}, 64'(frame_strobe), 64'(m_strobe));
    chk({tag, "_pend"}, 64'(frame_pending), 64'(m_pend));
    chk({tag, "_leds"}, 64'(leds), 64'(m_leds));
  endtask

  initial begin
    longint signed diff;
    bit          is_rd;
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0; frame_ack = 1'b0;
    mem_addr = 32'h0; mem_funct3 = 3'd0; write_data = 32'h0;
    m_leds = 16'h0; m_gen = 16'h0; m_pend = 0; m_err = 0; m_strobe = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_addr = MB + 32'd16; mem_funct3 = LW;
    #1;
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_pend", 64'(frame_pending), 64'd0);
    chk("rst_strobe", 64'(frame_strobe), 64'd0);
    chk("rst_status", 64'(read_data), 64'd0);
    reset = 1'b1;

    // Byte lanes and sign handling
    op(0, 1, 32'h10, LW, 32'hDEAD_BEEF, 0, "sw10");
    op(1, 0, 32'h10, LW, 32'h0, 0, "lw10");   chk("lw10_c", 64'(last_rd), 64'hDEAD_BEEF);
    op(0, 1, 32'h12, LB, 32'h0000_005A, 0, "sb12");
    op(1, 0, 32'h10, LW, 32'h0, 0, "lw10b");  chk("lw10b_c", 64'(last_rd), 64'hDE5A_BEEF);
    op(1, 0, 32'h12, LB, 32'h0, 0, "lb12");   chk("lb12_c", 64'(last_rd), 64'h0000_005A);
    op(1, 0, 32'h13, LBU, 32'h0, 0, "lbu13"); chk("lbu13_c", 64'(last_rd), 64'h0000_00DE);
    op(1, 0, 32'h13, LB, 32'h0, 0, "lb13");   chk("lb13_c", 64'(last_rd), 64'hFFFF_FFDE);

    // Halves, misalignment, sticky error and its clear
    op(0, 1, 32'h20, LH, 32'h0000_8001, 0, "sh20");
    op(1, 0, 32'h20, LH, 32'h0, 0, "lh20");   chk("lh20_c", 64'(last_rd), 64'hFFFF_8001);
    op(1, 0, 32'h20, LHU, 32'h0, 0, "lhu20"); chk("lhu20_c", 64'(last_rd), 64'h0000_8001);
    op(1, 0, 32'h22, LW, 32'h0, 0, "lw22");   chk("lw22_c", 64'(last_rd), 64'h0);
    op(1, 0, MB + 32'd16, LW, 32'h0, 0, "st_err"); chk("st_err_c", 64'(last_rd[1]), 64'd1);
    op(0, 1, MB + 32'd16, LW, 32'h2, 0, "st_clr");
    op(1, 0, MB + 32'd16, LW, 32'h0, 0, "st_ok");  chk("st_ok_c", 64'(last_rd[1]), 64'd0);

    // Cycle counter and coherent high snapshot
    while (tb_cyc < 100) @(posedge clk);
    op(1, 0, MB, LW, 32'h0, 0, "cyclo");
    diff = longint'(last_rd) - longint'(tb_cyc - 1);
    chk("cyclo_near", 64'((diff >= -1) && (diff <= 1)), 64'd1);
    op(1, 0, MB + 32'd4, LW, 32'h0, 0, "cychi"); chk("cychi_c", 64'(last_rd), 64'h0);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    mem_read = 1'b1; mem_addr = MB; mem_funct3 = LW;
    #1;
    chk("wrap_lo", 64'(read_data), 64'hFFFF_FFFF);
    release dut.cycle_q;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    op(1, 0, MB + 32'd4, LW, 32'h0, 0, "wrap_hi");  chk("wrap_hi_c", 64'(last_rd), 64'h0);
    op(1, 0, MB, LW, 32'h0, 0, "wrap_lo2");
    op(1, 0, MB + 32'd4, LW, 32'h0, 0, "wrap_hi2"); chk("wrap_hi2_c", 64'(last_rd), 64'h1);

    // Frame handshake
    op(0, 1, MB + 32'd12, LW, 32'h1234_5678, 0, "fw1");
    chk("fw1_strobe_hi", 64'(frame_strobe), 64'd1);
    op(0, 0, 32'h0, LW, 32'h0, 0, "idle1");
    chk("fw1_strobe_lo", 64'(frame_strobe), 64'd0);
    op(1, 0, MB + 32'd12, LW, 32'h0, 0, "fr1"); chk("fr1_c", 64'(last_rd), 64'd1);
    op(0, 0, 32'h0, LW, 32'h0, 1, "ack");      chk("ack_c", 64'(frame_pending), 64'd0);
    op(0, 1, MB + 32'd12, LW, 32'h0, 1, "fw_ack");
    chk("fw_ack_pend", 64'(frame_pending), 64'd1);
    op(1, 0, MB + 32'd12, LW, 32'h0, 0, "fr2"); chk("fr2_c", 64'(last_rd), 64'd2);
    op(0, 1, MB + 32'd12, LW, 32'h0, 0, "fwb1");
    op(0, 1, MB + 32'd12, LW, 32'h0, 0, "fwb2");
    chk("fwb_strobe", 64'(frame_strobe), 64'd1);
    op(1, 0, MB + 32'd12, LW, 32'h0, 0, "fr4"); chk("fr4_c", 64'(last_rd), 64'd4);

    // LEDs
    op(0, 1, MB + 32'd8, LW, 32'hFFFF_1234, 0, "ledw"); chk("ledw_c", 64'(leds), 64'h1234);
    op(1, 0, MB + 32'd8, LW, 32'h0, 0, "ledr");         chk("ledr_c", 64'(last_rd), 64'h1234);

    // Unmapped and non-word MMIO
    op(0, 1, 32'h0, LW, 32'hCAFE_F00D, 0, "sw0");
    op(0, 1, MB + 32'h100, LW, 32'h1111_1111, 0, "sw_unmap");
    op(1, 0, MB, LB, 32'h0, 0, "lb_mmio"); chk("lb_mmio_c", 64'(last_rd), 64'h0);
    op(0, 1, MB + 32'd16, LW, 32'h2, 0, "clr2");
    op(0, 1, 32'(4 * DEPTH), LW, 32'h5555_5555, 0, "sw_oob");
    op(1, 0, MB + 32'd16, LW, 32'h0, 0, "st_oob"); chk("st_oob_c", 64'(last_rd[1]), 64'd1);
    op(1, 0, 32'h0, LW, 32'h0, 0, "lw0");          chk("lw0_c", 64'(last_rd), 64'hCAFE_F00D);

    // Randomized traffic over a pre-initialized RAM region plus MMIO/unmapped spots
    for (int w = 0; w < 64; w++) op(0, 1, 32'(4 * w), LW, $urandom(), 0, "init");
    for (int k = 0; k < 250; k++) begin
      is_rd = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) begin
        a = 32'($urandom_range(0, 255));
      end else begin
        case ($urandom_range(0, 4))
          0:       a = MB + 32'd8;
          1:       a = MB + 32'd12;
          2:       a = MB + 32'd16;
          3:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
          default: a = $urandom();
        endcase
      end
      op(is_rd, !is_rd, a, f3, $urandom(), ($urandom_range(0, 3) == 0), "rand");
    end
    op(1, 0, MB + 32'd16, LW, 32'h0, 0, "rand_status");
    for (int w = 0; w < 64; w++) op(1, 0, 32'(4 * w), LW, 32'h0, 0, "final_word");

    // Asynchronous reset in the middle of a cycle
    op(0, 1, MB + 32'd8, LW, 32'h0000_ABCD, 0, "led_pre");
    op(0, 1, MB + 32'd12, LW, 32'h0, 0, "frame_pre");
    #2;
    reset = 1'b0;
    mem_addr = MB + 32'd12; mem_funct3 = LW;
    #1;
    chk("arst_leds", 64'(leds), 64'd0);
    chk("arst_pend", 64'(frame_pending), 64'd0);
    chk("arst_strobe", 64'(frame_strobe), 64'd0);
    chk("arst_gen", 64'(read_data), 64'd0);
    mem_addr = MB + 32'd16;
    #1;
    chk("arst_status", 64'(read_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
